// File: rtl/xnor_sweep_tester.sv
// Clocked exhaustive stimulus/checker for a 3-input XNOR circuit: sweeps {a,b,c}
// through 000..111, samples f once per vector and reports pass, error count and first failure.
module xnor_sweep_tester #(
    parameter int DWELL  = 4,   // cycles per vector, 2..255
    parameter int SETTLE = 1    // sample offset within the dwell, 1..DWELL-1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       c,
    input  logic       f,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic       fail_valid,
    output logic [2:0] first_fail
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [2:0] vec;
    logic [7:0] dwell;
    logic       sample;
    logic       last_dwell;
    logic       mismatch;
    logic [3:0] err_next;

    assign {a, b, c}  = vec;
    assign sample     = (state == RUN) && (dwell == 8'(SETTLE));
    assign last_dwell = (dwell == 8'(DWELL - 1));
    assign mismatch   = sample && (f != ~(^vec));
    assign err_next   = err_count + 4'(mismatch);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: next-state is defaulted first so no path through the case can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_dwell && vec == 3'd7) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vec        <= '0;
            dwell      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            first_fail <= '0;
        end else begin
            busy <= (state_next != IDLE);
            done <= (state_next == FINISH);
            case (state)
                IDLE: begin
                    if (start) begin
                        vec        <= '0;
                        dwell      <= '0;
                        pass       <= 1'b0;
                        err_count  <= '0;
                        fail_valid <= 1'b0;
                        first_fail <= '0;
                    end
                end
                RUN: begin
                    dwell <= dwell + 8'd1;
                    if (mismatch) begin
                        err_count <= err_next;
                        if (!fail_valid) begin
                            first_fail <= vec;
                            fail_valid <= 1'b1;
                        end
                    end
                    if (last_dwell) begin
                        dwell <= '0;
                        if (vec == 3'd7) begin
                            vec  <= '0;
                            // Latched on FINISH entry from err_next so pass is already valid alongside done.
                            pass <= (err_next == 4'd0);
                        end else begin
                            vec <= vec + 3'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_xnor_sweep_tester.sv
// Scoreboard bench for xnor_sweep_tester: a behavioural XNOR circuit with injectable per-vector
// faults drives f; expected sweep results are queued at start and compared when done pulses.
module tb_xnor_sweep_tester;

    localparam int D0 = 4;
    localparam int S0 = 1;
    localparam int D1 = 2;
    localparam int S1 = 1;

    typedef struct packed {
        int         inst;
        int         done_at;
        logic [3:0] err;
        logic       pass;
        logic       fv;
        logic [2:0] ff;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] start_v = '0;
    logic [1:0] a_v, b_v, c_v, f_v, busy_v, done_v, pass_v, fv_v;
    logic [3:0] err_v [2];
    logic [2:0] ff_v  [2];

    logic [7:0] mask_r   [2];
    logic       glitch_r [2];
    int         run_start[2];
    int         cnt = 0;
    int         errors = 0;
    int         checks = 0;
    exp_t       exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cnt <= cnt + 1;

    xnor_sweep_tester #(.DWELL(D0), .SETTLE(S0)) dut0 (
        .clk(clk), .reset(reset), .start(start_v[0]),
        .a(a_v[0]), .b(b_v[0]), .c(c_v[0]), .f(f_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
        .err_count(err_v[0]), .fail_valid(fv_v[0]), .first_fail(ff_v[0])
    );

    xnor_sweep_tester #(.DWELL(D1), .SETTLE(S1)) dut1 (
        .clk(clk), .reset(reset), .start(start_v[1]),
        .a(a_v[1]), .b(b_v[1]), .c(c_v[1]), .f(f_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
        .err_count(err_v[1]), .fail_valid(fv_v[1]), .first_fail(ff_v[1])
    );

    function automatic int dwell_of(input int i);
        return (i == 0) ? D0 : D1;
    endfunction

    function automatic int settle_of(input int i);
        return (i == 0) ? S0 : S1;
    endfunction

    // Circuit under test: ideal XNOR, flipped on vectors selected by the fault mask; in glitch
    // mode it is also wrong on every cycle of the dwell except the intended sample cycle.
    function automatic logic model_f(input logic [2:0] v, input logic [7:0] m, input logic g,
                                     input int t, input int d, input int s);
        logic r;
        r = ~(v[2] ^ v[1] ^ v[0]) ^ m[v];
        if (g && t >= 0 && (t % d) != s) r = ~r;
        return r;
    endfunction

    assign f_v[0] = model_f({a_v[0], b_v[0], c_v[0]}, mask_r[0], glitch_r[0],
                            (run_start[0] < 0) ? -1 : cnt - run_start[0], D0, S0);
    assign f_v[1] = model_f({a_v[1], b_v[1], c_v[1]}, mask_r[1], glitch_r[1],
                            (run_start[1] < 0) ? -1 : cnt - run_start[1], D1, S1);

    // Mismatches already sampled and registered by RUN cycle t.
    function automatic int err_upto(input logic [7:0] m, input int t, input int d, input int s);
        int n = 0;
        for (int k = 0; k < 8; k++) if (m[k] && k * d + s < t) n++;
        return n;
    endfunction

    function automatic int first_upto(input logic [7:0] m, input int t, input int d, input int s);
        for (int k = 0; k < 8; k++) if (m[k] && k * d + s < t) return k;
        return -1;
    endfunction

    function automatic exp_t make_exp(input int i, input logic [7:0] m, input int done_at);
        exp_t e;
        e.inst    = i;
        e.done_at = done_at;
        e.err     = 4'($countones(m));
        e.pass    = (m == 8'h00);
        e.fv      = (m != 8'h00);
        e.ff      = '0;
        for (int k = 7; k >= 0; k--) if (m[k]) e.ff = 3'(k);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cnt, act, exp);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest queued sweep.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            if (done_v[i]) begin
                if (exp_q.size() == 0 || exp_q[0].inst != i) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done inst%0d @cycle %0d: got done=1 expected done=0", i, cnt);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("done_cycle inst%0d", i), cnt, e.done_at);
                    check($sformatf("pass inst%0d", i), 32'(pass_v[i]), 32'(e.pass));
                    check($sformatf("err_count inst%0d", i), 32'(err_v[i]), 32'(e.err));
                    check($sformatf("fail_valid inst%0d", i), 32'(fv_v[i]), 32'(e.fv));
                    if (e.fv) check($sformatf("first_fail inst%0d", i), 32'(ff_v[i]), 32'(e.ff));
                end
            end
        end
    end

    // Per-cycle view of a sweep in progress: vector, busy and running result registers.
    always @(negedge clk) begin
        int t, d, s, fst;
        for (int i = 0; i < 2; i++) begin
            if (run_start[i] >= 0) begin
                t = cnt - run_start[i];
                d = dwell_of(i);
                s = settle_of(i);
                if (t >= 0 && t < 8 * d) begin
                    fst = first_upto(mask_r[i], t, d, s);
                    check($sformatf("vector inst%0d t=%0d", i, t), 32'({a_v[i], b_v[i], c_v[i]}), t / d);
                    check($sformatf("busy_run inst%0d t=%0d", i, t), 32'(busy_v[i]), 1);
                    check($sformatf("err_run inst%0d t=%0d", i, t), 32'(err_v[i]), err_upto(mask_r[i], t, d, s));
                    check($sformatf("fv_run inst%0d t=%0d", i, t), 32'(fv_v[i]), (fst >= 0) ? 1 : 0);
                    if (fst >= 0) check($sformatf("ff_run inst%0d t=%0d", i, t), 32'(ff_v[i]), fst);
                    check($sformatf("pass_run inst%0d t=%0d", i, t), 32'(pass_v[i]), 0);
                end else if (t == 8 * d) begin
                    check($sformatf("busy_finish inst%0d", i), 32'(busy_v[i]), 1);
                    check($sformatf("vector_finish inst%0d", i), 32'({a_v[i], b_v[i], c_v[i]}), 0);
                end else if (t == 8 * d + 1) begin
                    check($sformatf("busy_idle inst%0d", i), 32'(busy_v[i]), 0);
                end
            end
        end
    end

    task automatic wait_drain(input int bound);
        for (int n = 0; n < bound; n++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) return;
        end
        checks++;
        errors++;
        $display("FAIL timeout: got %0d pending sweeps after %0d cycles expected 0", exp_q.size(), bound);
        exp_q.delete();
    endtask

    task automatic check_zero(input int i, input string tag);
        check($sformatf("%s abc inst%0d", tag, i), 32'({a_v[i], b_v[i], c_v[i]}), 0);
        check($sformatf("%s busy inst%0d", tag, i), 32'(busy_v[i]), 0);
        check($sformatf("%s done inst%0d", tag, i), 32'(done_v[i]), 0);
        check($sformatf("%s pass inst%0d", tag, i), 32'(pass_v[i]), 0);
        check($sformatf("%s err_count inst%0d", tag, i), 32'(err_v[i]), 0);
        check($sformatf("%s fail_valid inst%0d", tag, i), 32'(fv_v[i]), 0);
        check($sformatf("%s first_fail inst%0d", tag, i), 32'(ff_v[i]), 0);
    endtask

    // Results must hold in IDLE after the sweep ends.
    task automatic check_idle(input int i, input logic [7:0] m);
        exp_t e;
        e = make_exp(i, m, 0);
        repeat (3) @(negedge clk);
        check($sformatf("hold busy inst%0d", i), 32'(busy_v[i]), 0);
        check($sformatf("hold done inst%0d", i), 32'(done_v[i]), 0);
        check($sformatf("hold abc inst%0d", i), 32'({a_v[i], b_v[i], c_v[i]}), 0);
        check($sformatf("hold pass inst%0d", i), 32'(pass_v[i]), 32'(e.pass));
        check($sformatf("hold err_count inst%0d", i), 32'(err_v[i]), 32'(e.err));
        check($sformatf("hold fail_valid inst%0d", i), 32'(fv_v[i]), 32'(e.fv));
        if (e.fv) check($sformatf("hold first_fail inst%0d", i), 32'(ff_v[i]), 32'(e.ff));
    endtask

    task automatic run_sweep(input int i, input logic [7:0] m, input logic g, input bit pulse);
        int d;
        d = dwell_of(i);
        @(negedge clk);
        #1;
        mask_r[i]   = m;
        glitch_r[i] = g;
        run_start[i] = cnt + 1;
        exp_q.push_back(make_exp(i, m, cnt + 1 + 8 * d));
        start_v[i] = 1'b1;
        @(negedge clk);
        #1;
        start_v[i] = 1'b0;
        if (pulse) begin
            repeat (6) @(negedge clk);
            #1;
            start_v[i] = 1'b1;
            @(negedge clk);
            #1;
            start_v[i] = 1'b0;
        end
        wait_drain(8 * d + 20);
        check_idle(i, m);
    endtask

    task automatic back_to_back(input int i, input logic [7:0] m0, input logic [7:0] m1,
                                input logic [7:0] m2);
        int d;
        logic [7:0] ms[3];
        d = dwell_of(i);
        ms[0] = m0;
        ms[1] = m1;
        ms[2] = m2;
        @(negedge clk);
        #1;
        mask_r[i]    = m0;
        glitch_r[i]  = 1'b0;
        run_start[i] = cnt + 1;
        exp_q.push_back(make_exp(i, m0, cnt + 1 + 8 * d));
        start_v[i] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_drain(8 * d + 20);
            if (k < 2) begin
                mask_r[i]    = ms[k + 1];
                run_start[i] = cnt + 2;
                exp_q.push_back(make_exp(i, ms[k + 1], cnt + 2 + 8 * d));
            end else begin
                start_v[i] = 1'b0;
            end
        end
        check_idle(i, m2);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            mask_r[i]    = '0;
            glitch_r[i]  = 1'b0;
            run_start[i] = -1;
        end
        repeat (3) @(negedge clk);
        check_zero(0, "reset");
        check_zero(1, "reset");
        #1;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_zero(0, "post_reset");

        run_sweep(0, 8'h00, 1'b0, 1'b0);   // correct circuit
        run_sweep(0, 8'hff, 1'b0, 1'b0);   // f = a^b^c
        run_sweep(0, 8'h96, 1'b0, 1'b0);   // f stuck at 1
        run_sweep(0, 8'h00, 1'b1, 1'b0);   // only right on the sample cycle
        for (int r = 0; r < 4; r++) run_sweep(0, 8'($urandom), 1'b0, r[0]);

        // Abort at cycle 13 of a failing sweep.
        @(negedge clk);
        #1;
        mask_r[0]    = 8'hff;
        glitch_r[0]  = 1'b0;
        run_start[0] = cnt + 1;
        exp_q.push_back(make_exp(0, 8'hff, cnt + 1 + 8 * D0));
        start_v[0] = 1'b1;
        @(negedge clk);
        #1;
        start_v[0] = 1'b0;
        repeat (13) @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_zero(0, "async_reset");
        exp_q.delete();
        run_start[0] = -1;
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b0;
        repeat (8 * D0) @(negedge clk);
        check_zero(0, "after_abort");
        run_sweep(0, 8'h00, 1'b0, 1'b0);

        back_to_back(0, 8'hff, 8'h00, 8'($urandom));

        run_sweep(1, 8'h00, 1'b0, 1'b0);
        run_sweep(1, 8'($urandom), 1'b0, 1'b1);
        run_sweep(1, 8'h00, 1'b1, 1'b0);
        run_sweep(1, 8'h80, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/xnor_sweep_tester.md
# xnor_sweep_tester

Self-checking stimulus stage that sits directly upstream of `xnor_circuit`: it drives the three circuit inputs `a`, `b`, `c` through all 8 combinations in ascending order and samples the circuit output `f` back. Each sample is compared against the 3-input XNOR reference `~(a ^ b ^ c)`. The block replaces the hand-timed `#100` stimulus with a clocked, repeatable sweep. It reports pass/fail, the error count and the first failing vector, so a board run can be checked on LEDs.

## Interface
Parameters:
- `DWELL`, 4: cycles each vector is held; legal range 2..255.
- `SETTLE`, 1: cycle offset within the dwell at which `f` is sampled; legal range 1..DWELL-1.

Ports:
- `clk`  in  1  single system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  level-sampled; starts a sweep when high in IDLE.
- `a`, `b`, `c`  out  1 each  stimulus to `xnor_circuit`; `{a,b,c}` equals the vector counter, with `a` as the MSB.
- `f`  in  1  output of `xnor_circuit`, combinational from `a`, `b`, `c`, same clock domain.
- `busy`  out  1  high while a sweep is in progress.
- `done`  out  1  one-cycle pulse at sweep end.
- `pass`  out  1  high when the last completed sweep had zero mismatches.
- `err_count`  out  4  number of mismatching vectors in the last or current sweep, range 0..8.
- `fail_valid`  out  1  high once any mismatch has been recorded in the current or last sweep.
- `first_fail`  out  3  `{a,b,c}` of the first mismatch; meaningful only when `fail_valid` is high.

## Operation
- FSM states: IDLE, RUN, FINISH.
- **IDLE**
  - On `start`=1: clear `err_count`, `fail_valid`, `first_fail` and `pass`; set vector to 0 and dwell counter to 0; go to RUN.
- **RUN**
  - `{a,b,c}` is driven from the registered vector counter.
  - The dwell counter increments each cycle.
  - When dwell counter = SETTLE, compare `f` with `~(a^b^c)`.
    - On mismatch: `err_count` += 1.
    - If `fail_valid` is 0: capture `first_fail` = vector and set `fail_valid`.
  - When dwell counter = DWELL-1:
    - If vector < 7: vector += 1 and dwell counter = 0.
    - If vector = 7: go to FINISH; vector wraps to 0.
- **FINISH** (one cycle)
  - Pulse `done`.
  - Set `pass` = (`err_count` == 0).
  - Go to IDLE.
- `start` is ignored outside IDLE.
  - If `start` is still high on the IDLE cycle after FINISH, a new sweep begins. Continuous `start` therefore gives back-to-back sweeps.
- `err_count` is 4 bits and saturates by construction, since the maximum is 8.
- Results (`pass`, `err_count`, `fail_valid`, `first_fail`) hold until the next accepted `start`.

## Timing
- Reset values: `a`=`b`=`c`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_valid`=0, `first_fail`=0. State is IDLE.
- Reset asserted mid-sweep aborts immediately and asynchronously to the reset values. No `done` pulse is produced.
- `busy`:
  - Rises on the first clock edge after `start` is seen in IDLE.
  - Stays high through RUN and FINISH.
  - Falls on the edge that enters IDLE.
- Vector k is applied during cycles k·DWELL .. k·DWELL+DWELL-1, counted from RUN entry (cycle 0).
- `f` is sampled at cycle k·DWELL+SETTLE.
- Sweep length: 8·DWELL cycles in RUN plus 1 cycle in FINISH. `done` is high in cycle 8·DWELL, counted from RUN entry.
- `err_count` updates are registered and visible the cycle after the sample.
- `pass` is valid from the cycle `done` is high.
- All outputs are registered; nothing is combinational from `f` to any output.

## Test plan
- Correct DUT, DWELL=4, SETTLE=1, `start` pulsed once:
  - `{a,b,c}` steps 000→111, 4 cycles each.
  - `done` is high at cycle 32.
  - `pass`=1, `err_count`=0, `fail_valid`=0.
- Faulty DUT `f = a^b^c` (inverted):
  - All 8 vectors mismatch: `err_count`=8, `pass`=0, `first_fail`=000.
- Faulty DUT `f` stuck-at-1:
  - Mismatches at 001, 010, 100, 111: `err_count`=4, `first_fail`=001.
- Reset asserted at cycle 13 of a sweep:
  - All outputs return to reset values immediately, with no `done`.
  - A fresh `start` then yields a full 33-cycle sweep.
- `start` held high for 3 sweeps:
  - `done` pulses at cycles 32, 66 and 100 (one IDLE cycle between sweeps).
  - Results are cleared at each restart.
  - `start` pulses during RUN are ignored.
- DWELL=2, SETTLE=1:
  - Vectors change every 2 cycles and `f` is sampled on the second cycle.
  - With a correct DUT: `pass`=1, `done` at cycle 16.
